// File: rtl/fifo_stream_packer_pkg.sv
// fifo_stream_packer_pkg: shared FSM state type, default parameters and output width derivation.
package fifo_stream_packer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int IN_W_DEF      = 64;
    localparam int RATIO_DEF     = 4;
    localparam int N_CH_DEF      = 2;
    localparam int PKT_WORDS_DEF = 16;
    localparam int TMO_W_DEF     = 16;

    function automatic int out_width(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

endpackage

// File: rtl/fifo_stream_lane_reg.sv
// fifo_stream_lane_reg: assembles RATIO input words into one wide word.
//   clk, rst   : clock, async active-high reset
//   load, din  : write din into lane lane_idx and advance lane_idx
//   clear      : empty the register (wins over load)
//   lane_idx   : next lane to fill; equals RATIO while a complete word is held
//   next_word  : register contents including a lane being loaded this cycle
module fifo_stream_lane_reg
    import fifo_stream_packer_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int RATIO = RATIO_DEF,
    localparam int OUT_W = out_width(IN_W, RATIO),
    localparam int LW    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [IN_W-1:0]  din,
    output logic [LW-1:0]    lane_idx,
    output logic [OUT_W-1:0] next_word
);

    logic [OUT_W-1:0] lanes;

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign next_word[g*IN_W +: IN_W] = (load && lane_idx == LW'(g)) ? din : lanes[g*IN_W +: IN_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes    <= '0;
            lane_idx <= '0;
        end else begin
            lanes    <= clear ? '0 : next_word;
            lane_idx <= clear ? '0 : load ? lane_idx + LW'(1) : lane_idx;
        end
    end

endmodule

// File: rtl/fifo_stream_packer.sv
// fifo_stream_packer: packs RATIO upstream FIFO words into wide words and streams them
// as packets of PKT_WORDS words, rotating round-robin over N_CH output channels.
//   clk_clk, reset_reset          : clock, async active-high reset
//   enable                        : permits upstream reads
//   flush_timeout                 : idle cycles before a partial flush (0 = never)
//   from_fifo_fifo_data/_empty    : show-ahead upstream word and empty flag
//   from_fifo_fifo_read           : upstream pop
//   fifo_stream_fifo_data         : packed word, shared by all channels
//   fifo_stream_fifo_write/_send  : one-hot write strobe and end-of-packet flag
//   fifo_stream_fifo_full         : per-channel backpressure
//   pkt_count                     : completed packets
module fifo_stream_packer
    import fifo_stream_packer_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int RATIO     = RATIO_DEF,
    parameter int N_CH      = N_CH_DEF,
    parameter int PKT_WORDS = PKT_WORDS_DEF,
    parameter int TMO_W     = TMO_W_DEF,
    localparam int OUT_W    = out_width(IN_W, RATIO)
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             enable,
    input  logic [TMO_W-1:0] flush_timeout,
    input  logic [IN_W-1:0]  from_fifo_fifo_data,
    input  logic             from_fifo_fifo_empty,
    output logic             from_fifo_fifo_read,
    output logic [OUT_W-1:0] fifo_stream_fifo_data,
    output logic [N_CH-1:0]  fifo_stream_fifo_write,
    output logic [N_CH-1:0]  fifo_stream_fifo_send,
    input  logic [N_CH-1:0]  fifo_stream_fifo_full,
    output logic [31:0]      pkt_count
);

    localparam int LW = $clog2(RATIO + 1);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int WW = PKT_WORDS > 1 ? $clog2(PKT_WORDS) : 1;

    state_t           state, state_nxt;
    logic [LW-1:0]    lane_idx;
    logic [OUT_W-1:0] next_word;
    logic [CW-1:0]    cur_ch;
    logic [WW-1:0]    word_cnt;
    logic [TMO_W-1:0] idle;
    logic             pend_send;
    logic             rd, complete, flush, full_cur, issue, eop;

    fifo_stream_lane_reg #(.IN_W(IN_W), .RATIO(RATIO)) u_lane (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .load      (rd),
        .clear     (issue),
        .din       (from_fifo_fifo_data),
        .lane_idx  (lane_idx),
        .next_word (next_word)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= FILL;
        else             state <= state_nxt;
    end

    // Flush fires on the cycle the idle counter would reach flush_timeout, so the
    // registered write appears exactly flush_timeout idle cycles after the last read.
    // Any read (including a completing one) suppresses the flush.
    always_comb begin
        full_cur            = fifo_stream_fifo_full[cur_ch];
        rd                  = enable && !from_fifo_fifo_empty && state == FILL;
        complete            = rd && lane_idx == LW'(RATIO - 1);
        flush               = state == FILL && !rd && flush_timeout != '0 &&
                              idle + TMO_W'(1) == flush_timeout &&
                              (lane_idx != '0 || word_cnt != '0);
        issue               = !full_cur && (complete || flush || state == STALL);
        eop                 = flush || pend_send || word_cnt == WW'(PKT_WORDS - 1);
        state_nxt           = full_cur && (state == STALL || complete || flush) ? STALL : FILL;
        from_fifo_fifo_read = rd;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            fifo_stream_fifo_write <= '0;
            fifo_stream_fifo_send  <= '0;
            fifo_stream_fifo_data  <= '0;
            pkt_count              <= '0;
            word_cnt               <= '0;
            cur_ch                 <= '0;
            idle                   <= '0;
            pend_send              <= 1'b0;
        end else begin
            fifo_stream_fifo_write <= issue ? N_CH'(1) << cur_ch : '0;
            fifo_stream_fifo_send  <= issue && eop ? N_CH'(1) << cur_ch : '0;
            if (issue) begin
                fifo_stream_fifo_data <= next_word;
                word_cnt              <= eop ? '0 : word_cnt + WW'(1);
            end
            if (issue && eop) begin
                cur_ch    <= cur_ch == CW'(N_CH - 1) ? '0 : cur_ch + CW'(1);
                pkt_count <= pkt_count + 32'd1;
            end
            // A flush blocked by backpressure must still end the packet once it drains.
            pend_send <= issue ? 1'b0 : flush || pend_send;
            idle      <= (rd || issue) ? '0 :
                         (state == FILL && idle != '1) ? idle + TMO_W'(1) : idle;
        end
    end

endmodule

// File: tb/tb_fifo_stream_packer.sv
// tb_fifo_stream_packer: directed self-checking bench for fifo_stream_packer.
module tb_fifo_stream_packer;

    localparam int IN_W  = 64;
    localparam int OUT_W = 256;
    localparam int N_CH  = 2;
    localparam int TMO_W = 16;

    typedef struct {
        int               cyc;
        logic [N_CH-1:0]  wr;
        logic [N_CH-1:0]  sd;
        logic [OUT_W-1:0] data;
        logic [N_CH-1:0]  full_prev;
    } wlog_t;

    logic             clk_clk = 1'b0;
    logic             reset_reset;
    logic             enable;
    logic [TMO_W-1:0] flush_timeout;
    logic [IN_W-1:0]  from_fifo_fifo_data;
    logic             from_fifo_fifo_empty;
    logic             from_fifo_fifo_read;
    logic [OUT_W-1:0] fifo_stream_fifo_data;
    logic [N_CH-1:0]  fifo_stream_fifo_write;
    logic [N_CH-1:0]  fifo_stream_fifo_send;
    logic [N_CH-1:0]  fifo_stream_fifo_full;
    logic [31:0]      pkt_count;

    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    logic [IN_W-1:0] q[$];
    int              rd_cyc[$];
    wlog_t           wl[$];

    fifo_stream_packer dut (
        .clk_clk                (clk_clk),
        .reset_reset            (reset_reset),
        .enable                 (enable),
        .flush_timeout          (flush_timeout),
        .from_fifo_fifo_data    (from_fifo_fifo_data),
        .from_fifo_fifo_empty   (from_fifo_fifo_empty),
        .from_fifo_fifo_read    (from_fifo_fifo_read),
        .fifo_stream_fifo_data  (fifo_stream_fifo_data),
        .fifo_stream_fifo_write (fifo_stream_fifo_write),
        .fifo_stream_fifo_send  (fifo_stream_fifo_send),
        .fifo_stream_fifo_full  (fifo_stream_fifo_full),
        .pkt_count              (pkt_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] pk(input logic [IN_W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drive();
        from_fifo_fifo_empty = (q.size() == 0);
        from_fifo_fifo_data  = q.size() != 0 ? q[0] : '0;
    endtask

    task automatic push(input logic [IN_W-1:0] v);
        q.push_back(v);
        drive();
    endtask

    // One clock: sample the combinational read before the edge, then model the
    // upstream pop and log any write visible after the edge.
    task automatic cycle();
        logic            r;
        logic [N_CH-1:0] fp;
        #1;
        r  = from_fifo_fifo_read;
        fp = fifo_stream_fifo_full;
        if (r) rd_cyc.push_back(cyc);
        @(posedge clk_clk);
        #1;
        cyc++;
        if (r) void'(q.pop_front());
        drive();
        if (fifo_stream_fifo_write != '0)
            wl.push_back('{cyc, fifo_stream_fifo_write, fifo_stream_fifo_send, fifo_stream_fifo_data, fp});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        wl.delete();
    endtask

    task automatic reset_dut();
        reset_reset = 1'b1;
        q.delete();
        drive();
        run(2);
        reset_reset = 1'b0;
        clear_logs();
    endtask

    function automatic int reads_in(input int a, input int b);
        int n = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] >= a && rd_cyc[i] <= b) n++;
        return n;
    endfunction

    function automatic int full_violations();
        int n = 0;
        foreach (wl[i]) if ((wl[i].wr & wl[i].full_prev) != '0) n++;
        return n;
    endfunction

    initial begin
        int h, f, n;
        reset_reset           = 1'b1;
        enable                = 1'b0;
        flush_timeout         = '0;
        fifo_stream_fifo_full = '0;
        drive();
        run(2);
        check("rst_write", fifo_stream_fifo_write, 0);
        check("rst_send", fifo_stream_fifo_send, 0);
        check("rst_data", fifo_stream_fifo_data, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_read", from_fifo_fifo_read, 0);
        reset_reset = 1'b0;
        enable      = 1'b1;
        clear_logs();

        // Two full words on ch0
        for (int i = 1; i <= 8; i++) push(IN_W'(i));
        run(12);
        check("t1_nwr", wl.size(), 2);
        check("t1_wr0", wl[0].wr, 2'b01);
        check("t1_d0", wl[0].data, pk(1, 2, 3, 4));
        check("t1_s0", wl[0].sd, 0);
        check("t1_lat0", wl[0].cyc, rd_cyc[3] + 1);
        check("t1_d1", wl[1].data, pk(5, 6, 7, 8));
        check("t1_s1", wl[1].sd, 0);
        check("t1_lat1", wl[1].cyc, rd_cyc[7] + 1);

        // Full packet then first word of the next packet on ch1
        reset_dut();
        for (int i = 1; i <= 68; i++) push(IN_W'(i));
        run(90);
        check("t2_nwr", wl.size(), 17);
        check("t2_d0", wl[0].data, pk(1, 2, 3, 4));
        n = 0;
        for (int i = 0; i < 15; i++) if (wl[i].sd != '0 || wl[i].wr != 2'b01) n++;
        check("t2_early", n, 0);
        check("t2_wr15", wl[15].wr, 2'b01);
        check("t2_sd15", wl[15].sd, 2'b01);
        check("t2_wr16", wl[16].wr, 2'b10);
        check("t2_sd16", wl[16].sd, 0);
        check("t2_d16", wl[16].data, pk(65, 66, 67, 68));
        check("t2_pkt", pkt_count, 1);

        // Partial flush after 10 idle cycles
        reset_dut();
        flush_timeout = 16'd10;
        push(64'hA);
        push(64'hB);
        push(64'hC);
        run(20);
        check("t3_nwr", wl.size(), 1);
        check("t3_data", wl[0].data, pk(64'hA, 64'hB, 64'hC, 0));
        check("t3_wr", wl[0].wr, 2'b01);
        check("t3_send", wl[0].sd, 2'b01);
        check("t3_lat", wl[0].cyc - rd_cyc[2], 11);
        check("t3_pkt", pkt_count, 1);
        flush_timeout = '0;
        clear_logs();
        for (int i = 1; i <= 4; i++) push(IN_W'(i));
        run(8);
        check("t3_nxt_ch", wl[0].wr, 2'b10);
        check("t3_nxt_d", wl[0].data, pk(1, 2, 3, 4));

        // Backpressure on ch0 across the completing read
        reset_dut();
        for (int i = 1; i <= 3; i++) push(IN_W'(i));
        run(4);
        h = cyc;
        fifo_stream_fifo_full = 2'b01;
        for (int i = 4; i <= 8; i++) push(IN_W'(i));
        run(6);
        f = cyc;
        fifo_stream_fifo_full = 2'b00;
        run(12);
        check("t4_rd_hold", reads_in(h, f), 1);
        n = 0;
        foreach (wl[i]) if (wl[i].cyc <= f) n++;
        check("t4_wr_hold", n, 0);
        check("t4_lat", wl[0].cyc, f + 1);
        check("t4_d0", wl[0].data, pk(1, 2, 3, 4));
        check("t4_d1", wl[1].data, pk(5, 6, 7, 8));
        check("t4_nofull", full_violations(), 0);

        // Reset mid-word discards partial data
        reset_dut();
        push(64'h11);
        push(64'h22);
        run(3);
        reset_reset = 1'b1;
        run(2);
        check("t5_write", fifo_stream_fifo_write, 0);
        check("t5_send", fifo_stream_fifo_send, 0);
        check("t5_data", fifo_stream_fifo_data, 0);
        check("t5_nwr_rst", wl.size(), 0);
        reset_reset = 1'b0;
        clear_logs();
        for (int i = 'h31; i <= 'h34; i++) push(IN_W'(i));
        run(8);
        check("t5_nwr", wl.size(), 1);
        check("t5_d", wl[0].data, pk(64'h31, 64'h32, 64'h33, 64'h34));

        // enable low halts reads; zero timeout never flushes
        reset_dut();
        enable = 1'b0;
        push(64'h1);
        push(64'h2);
        push(64'h3);
        run(5);
        check("t6_en_rd", rd_cyc.size(), 0);
        enable = 1'b1;
        run(1000);
        check("t6_rd", rd_cyc.size(), 3);
        check("t6_nwr", wl.size(), 0);
        check("t6_pkt", pkt_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
